// File: rtl/gpu_pkg.sv
// Shared MiniGPU encodings used by the scheduler, register file and LSU.
package gpu_pkg;

    localparam int DATA_BITS_DEFAULT = 8;
    localparam int ADDR_BITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit.sv
// Per-thread load/store unit: one valid/ready transaction to data memory per
// LDR/STR, with the loaded byte held on lsu_out for register write-back.
module load_store_unit
    import gpu_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT,
    parameter int ADDR_BITS = ADDR_BITS_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 mem_read_enable,
    input  logic                 mem_write_enable,
    input  logic [DATA_BITS-1:0] rs_data,
    input  logic [DATA_BITS-1:0] rt_data,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out
);

    lsu_state_t           state_q, state_d;
    logic                 op_read_q, op_read_d;
    logic                 rd_valid_d, wr_valid_d;
    logic [ADDR_BITS-1:0] rd_addr_d, wr_addr_d;
    logic [DATA_BITS-1:0] wr_data_d, lsu_out_d;

    // NOTE: every next-value signal takes its current value first, so paths that
    // do not assign it (including enable low) hold state without inferring latches.
    always_comb begin
        state_d    = state_q;
        op_read_d  = op_read_q;
        rd_valid_d = mem_read_valid;
        wr_valid_d = mem_write_valid;
        rd_addr_d  = mem_read_address;
        wr_addr_d  = mem_write_address;
        wr_data_d  = mem_write_data;
        lsu_out_d  = lsu_out;

        if (enable) begin
            unique case (state_q)
                LSU_IDLE: begin
                    if (core_state == CORE_REQUEST) begin
                        // Read takes priority when both decode flags are set.
                        if (mem_read_enable) begin
                            op_read_d = 1'b1;
                            state_d   = LSU_REQUESTING;
                        end else if (mem_write_enable) begin
                            op_read_d = 1'b0;
                            state_d   = LSU_REQUESTING;
                        end
                    end
                end
                LSU_REQUESTING: begin
                    if (op_read_q) begin
                        rd_addr_d  = ADDR_BITS'(rs_data);
                        rd_valid_d = 1'b1;
                    end else begin
                        wr_addr_d  = ADDR_BITS'(rs_data);
                        wr_data_d  = rt_data;
                        wr_valid_d = 1'b1;
                    end
                    state_d = LSU_WAITING;
                end
                LSU_WAITING: begin
                    if (op_read_q && mem_read_ready) begin
                        lsu_out_d  = mem_read_data;
                        rd_valid_d = 1'b0;
                        state_d    = LSU_DONE;
                    end else if (!op_read_q && mem_write_ready) begin
                        wr_valid_d = 1'b0;
                        state_d    = LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    if (core_state == CORE_UPDATE) begin
                        state_d = LSU_IDLE;
                    end
                end
                default: state_d = LSU_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= LSU_IDLE;
            op_read_q         <= 1'b0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            lsu_out           <= '0;
        end else begin
            state_q           <= state_d;
            op_read_q         <= op_read_d;
            mem_read_valid    <= rd_valid_d;
            mem_read_address  <= rd_addr_d;
            mem_write_valid   <= wr_valid_d;
            mem_write_address <= wr_addr_d;
            mem_write_data    <= wr_data_d;
            lsu_out           <= lsu_out_d;
        end
    end

    assign lsu_state = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected transactions,
// a negedge monitor pops and compares each one as the DUT reaches DONE.
module tb_load_store_unit;
    import gpu_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic       mem_read_enable, mem_write_enable;
    logic [7:0] rs_data, rt_data;
    logic       mem_read_valid, mem_write_valid;
    logic [7:0] mem_read_address, mem_write_address, mem_write_data;
    logic       mem_read_ready, mem_write_ready;
    logic [7:0] mem_read_data;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;

    typedef struct {
        bit         is_read;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] lsu_out;
        int         valid_cycles;
        int         latency;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    load_store_unit #(.DATA_BITS(8), .ADDR_BITS(8)) dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .core_state        (core_state),
        .mem_read_enable   (mem_read_enable),
        .mem_write_enable  (mem_write_enable),
        .rs_data           (rs_data),
        .rt_data           (rt_data),
        .mem_read_valid    (mem_read_valid),
        .mem_read_address  (mem_read_address),
        .mem_read_ready    (mem_read_ready),
        .mem_read_data     (mem_read_data),
        .mem_write_valid   (mem_write_valid),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_write_ready   (mem_write_ready),
        .lsu_state         (lsu_state),
        .lsu_out           (lsu_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor state
    int         cycle = 0;
    int         req_cycle = 0;
    int         valid_cnt = 0;
    bit         seen_rd = 0, seen_wr = 0, prev_done = 0;
    logic [7:0] seen_addr = '0, seen_wdata = '0;

    always @(negedge clock) begin
        exp_t e;
        cycle++;
        if (reset) begin
            valid_cnt = 0; seen_rd = 0; seen_wr = 0; prev_done = 0;
        end else begin
            if (mem_read_valid || mem_write_valid)
                check("one_valid", 32'(mem_read_valid && mem_write_valid), 32'd0);
            if (lsu_state == LSU_IDLE && enable && core_state == CORE_REQUEST &&
                (mem_read_enable || mem_write_enable))
                req_cycle = cycle;
            if (mem_read_valid) begin
                seen_rd = 1; valid_cnt++; seen_addr = mem_read_address;
            end
            if (mem_write_valid) begin
                seen_wr = 1; valid_cnt++; seen_addr = mem_write_address;
                seen_wdata = mem_write_data;
            end
            if (lsu_state == LSU_DONE && !prev_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("op_read",      32'(seen_rd), 32'(e.is_read));
                    check("op_write",     32'(seen_wr), 32'(!e.is_read));
                    check("address",      32'(seen_addr), 32'(e.addr));
                    if (!e.is_read) check("write_data", 32'(seen_wdata), 32'(e.wdata));
                    check("lsu_out",      32'(lsu_out), 32'(e.lsu_out));
                    check("valid_cycles", 32'(valid_cnt), 32'(e.valid_cycles));
                    check("latency",      32'(cycle - req_cycle), 32'(e.latency));
                    check("valids_low",   32'({mem_read_valid, mem_write_valid}), 32'd0);
                end
                valid_cnt = 0; seen_rd = 0; seen_wr = 0;
            end
            prev_done = (lsu_state == LSU_DONE);
        end
    end

    task automatic set_ready(input bit is_rd, input logic v);
        if (is_rd) mem_read_ready = v;
        else       mem_write_ready = v;
    endtask

    // stall: ready-low WAITING cycles; gap: enable-low cycles with ready high;
    // hold: DONE cycles before UPDATE.
    task automatic run_txn(input bit is_rd, input bit re, input bit we,
                           input logic [7:0] rs, input logic [7:0] rt, input logic [7:0] rdata,
                           input int stall, input int gap, input int hold,
                           input logic [7:0] exp_lsu);
        exp_t e;
        e.is_read = is_rd; e.addr = rs; e.wdata = rt; e.lsu_out = exp_lsu;
        e.valid_cycles = 1 + stall + gap;
        e.latency      = 3 + stall + gap;
        exp_q.push_back(e);

        core_state = CORE_REQUEST; mem_read_enable = re; mem_write_enable = we;
        rs_data = rs; rt_data = rt;
        tick();
        core_state = CORE_WAIT;
        tick();
        repeat (stall) tick();
        if (gap > 0) begin
            enable = 1'b0;
            set_ready(is_rd, 1'b1);
            mem_read_data = 8'hEE;
            for (int i = 0; i < gap; i++) begin
                tick();
                check("gap_state", 32'(lsu_state), 32'(LSU_WAITING));
                check("gap_valid", 32'(is_rd ? mem_read_valid : mem_write_valid), 32'd1);
            end
            enable = 1'b1;
        end
        set_ready(is_rd, 1'b1);
        mem_read_data = rdata;
        tick();
        set_ready(is_rd, 1'b0);
        if (hold > 0) begin
            mem_read_ready = 1'b1; mem_write_ready = 1'b1; mem_read_data = 8'h11;
            for (int i = 0; i < hold; i++) begin
                tick();
                check("hold_done",    32'(lsu_state), 32'(LSU_DONE));
                check("hold_lsu_out", 32'(lsu_out), 32'(exp_lsu));
            end
            mem_read_ready = 1'b0; mem_write_ready = 1'b0;
        end
        core_state = CORE_UPDATE;
        tick();
        check("to_idle", 32'(lsu_state), 32'(LSU_IDLE));
        core_state = CORE_IDLE; mem_read_enable = 1'b0; mem_write_enable = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; core_state = CORE_IDLE;
        mem_read_enable = 1'b0; mem_write_enable = 1'b0;
        rs_data = '0; rt_data = '0;
        mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = '0;
        tick();
        tick();
        check("rst_state",    32'(lsu_state), 32'(LSU_IDLE));
        check("rst_rvalid",   32'(mem_read_valid), 32'd0);
        check("rst_wvalid",   32'(mem_write_valid), 32'd0);
        check("rst_raddr",    32'(mem_read_address), 32'd0);
        check("rst_waddr",    32'(mem_write_address), 32'd0);
        check("rst_wdata",    32'(mem_write_data), 32'd0);
        check("rst_lsu_out",  32'(lsu_out), 32'd0);
        reset = 1'b0;
        tick();

        // Load, zero wait
        run_txn(1'b1, 1'b1, 1'b0, 8'h2A, 8'h00, 8'h5C, 0, 0, 0, 8'h5C);
        // Store with 4-cycle ready stall; lsu_out keeps the last load
        run_txn(1'b0, 1'b0, 1'b1, 8'h10, 8'hFF, 8'h00, 4, 0, 0, 8'h5C);
        // Both enables: read wins
        run_txn(1'b1, 1'b1, 1'b1, 8'h33, 8'hC3, 8'h77, 0, 0, 0, 8'h77);
        // enable low for 3 WAITING cycles with ready pulsed
        run_txn(1'b1, 1'b1, 1'b0, 8'h44, 8'h00, 8'h99, 0, 3, 0, 8'h99);

        // Reset while WAITING aborts the transaction
        core_state = CORE_REQUEST; mem_read_enable = 1'b1; rs_data = 8'h55;
        tick();
        core_state = CORE_WAIT;
        tick();
        check("pre_rst_state",  32'(lsu_state), 32'(LSU_WAITING));
        check("pre_rst_rvalid", 32'(mem_read_valid), 32'd1);
        reset = 1'b1;
        tick();
        check("abort_state",   32'(lsu_state), 32'(LSU_IDLE));
        check("abort_rvalid",  32'(mem_read_valid), 32'd0);
        check("abort_wvalid",  32'(mem_write_valid), 32'd0);
        check("abort_lsu_out", 32'(lsu_out), 32'd0);
        tick();
        reset = 1'b0; mem_read_enable = 1'b0; core_state = CORE_IDLE;
        tick();

        // DONE held 10 cycles (ready high ignored there), then UPDATE
        run_txn(1'b1, 1'b1, 1'b0, 8'hFE, 8'h00, 8'hA5, 0, 0, 10, 8'hA5);
        // New request accepted after returning to IDLE
        run_txn(1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 8'h00, 0, 0, 0, 8'hA5);

        tick();
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
